// File: rtl/seq_mult_param.sv
// seq_mult_param: parametrised right-shifting shift-add multiplier.
// One multiplier bit is consumed per clock; signed operands are handled by
// multiplying magnitudes and negating the final product when signs differ.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      request a new multiply (sampled only while busy=0)
//   is_signed  1 = two's-complement operands, 0 = unsigned
//   a          multiplicand (WIDTH bits)
//   b          multiplier   (WIDTH bits)
//   busy       high while an operation is in progress (WIDTH+1 cycles)
//   done       one-cycle pulse when product updates
//   product    held result register (2*WIDTH bits)
module seq_mult_param #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   lo;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mag;
  logic               last_bit;

  // The most-negative operand negates to 2^(WIDTH-1), which is still exact
  // when the WIDTH-bit result is read as unsigned.
  always_comb begin
    a_mag = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  // acc stays below 2^WIDTH after each shift, so acc + mcand fits WIDTH+1 bits.
  always_comb begin
    sum      = acc + {1'b0, (mplier[0] ? mcand : '0)};
    mag      = {acc[WIDTH-1:0], lo};
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    unique case (state)
      IDLE:    if (start)    state_next = RUN;
      RUN:     if (last_bit) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      lo      <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            lo     <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          lo     <= {sum[0], lo[WIDTH-1:1]};
          acc    <= {1'b0, sum[WIDTH:1]};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
        end
        FINISH: begin
          // Two's-complement negation of zero is zero, so no -0 artefact.
          product <= neg ? (~mag + 1'b1) : mag;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_mult_param.md
Name: seq_mult_param

Overview:
- Parametrised sequential shift-add multiplier, right-shifting: one multiplier bit is processed per clock.
- Successor to the team's fixed 6-bit unsigned sequential multiplier. Adds a generic operand width, per-operation signed/unsigned mode, a start/busy/done handshake and a held result register.
- Sits as a low-area multiply unit beside datapath blocks that can tolerate multi-cycle latency.

Parameters:
- WIDTH, 6, operand width in bits; legal range 2..32; product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new multiply; sampled only while busy=0
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; captured with operands
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when product updates
- product  output  2*WIDTH  result register; holds the last completed result

Behaviour:
- Reset (asynchronous, immediate on rst=1): busy=0, done=0, product=0, state=IDLE, all internal registers 0. Reset mid-operation aborts the operation; no done pulse follows.
- States: IDLE, RUN, FINISH.
- IDLE:
  - On an edge with start=1, capture a, b and is_signed, then go to RUN.
  - If is_signed=1, capture |a| and |b| as WIDTH-bit unsigned magnitudes. Record neg = sign(a) XOR sign(b).
  - Clear the accumulator (WIDTH+1 bits) and the bit counter. busy=1 from this edge.
- RUN, one multiplier bit per edge, LSB first:
  - If the current multiplier bit is 1, add the multiplicand to the accumulator.
  - Shift the accumulator LSB into the low half of the result; shift the accumulator right by 1.
  - Increment the counter. After WIDTH RUN edges, go to FINISH.
- FINISH, one edge:
  - Upper half of the result = accumulator[WIDTH-1:0].
  - If neg=1, product = two's-complement negation of the 2*WIDTH magnitude; otherwise product = magnitude.
  - done=1 for exactly this following cycle. busy=0. Return to IDLE.
- Latency: start is sampled at edge k. product and done update at edge k+WIDTH+1. busy is high for WIDTH+1 cycles.
- product changes only at the FINISH edge or on reset. It is stable at all other times, including during RUN.
- start=1 while busy=1 is ignored: no queuing, and the operands in flight are unaffected.
- start=1 in the same cycle that done=1 is accepted, giving back-to-back operation. Throughput is one result per WIDTH+1 cycles.
- Operands and is_signed may change freely after the capture edge.
- Signed edge case: the most-negative operand (-2^(WIDTH-1)) has magnitude 2^(WIDTH-1), which must be representable in the WIDTH-bit unsigned magnitude. The full signed product always fits in 2*WIDTH bits.
- Zero operand: a zero result with neg=1 must produce product=0, not a negative zero artefact.
- No overflow or truncation is possible; product is exact for both modes.

Test Plan (WIDTH=6 unless noted):
- Reset, then unsigned a=63, b=63, start for 1 cycle -> busy high for 7 cycles; done pulses 7 edges after capture; product=3969 (0xF81).
- Signed a=-5 (0x3B), b=7 -> product=0xFDD (-35). Signed a=-32, b=-32 -> product=0x400 (1024). Signed a=0, b=-1 -> product=0.
- Start issued again while busy with a=1, b=1 -> ignored; the first result is unchanged. Start asserted in the done cycle with a=2, b=3 unsigned -> accepted; product=6 seven edges later.
- Assert rst asynchronously mid-RUN (between clock edges) -> busy, done and product are 0 immediately; no later done pulse; a new operation works normally.
- Change a, b and is_signed every cycle during RUN -> result still matches the values captured at the start edge; product holds the previous value until the FINISH edge.
- WIDTH=8: exhaustive or random sweep in both modes against a reference multiply -> all match. Includes 255*255=65025 and signed -128*-128=16384.
